fir_tap_scheduler: RTL and testbench

// - Sequencer for a single-multiplier FIR: stores N_TAPS coefficients and the sample delay line.
// - Steps one shared multiply-accumulate across all taps, one tap per cycle, and emits one output word per sample.
// - Sits between the pin-level input/output mux and the output pins.
// - Replaces the fully parallel 5-multiplier FIR with a time-multiplexed datapath.

---
 rtl/fir_tap_scheduler_pkg.sv | 19 +
 rtl/fir_tap_scheduler_if.sv | 24 ++
 rtl/fir_tap_scheduler_mac.sv | 33 +++
 rtl/fir_tap_scheduler.sv | 150 +++++++++++++++
 tb/tb_fir_tap_scheduler.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/fir_tap_scheduler_pkg.sv
// Shared widths, FSM state encoding and counter sizing for the time-multiplexed FIR.
package fir_pkg;

  localparam int N_TAPS     = 5;
  localparam int BW_in      = 6;
  localparam int BW_product = 2 * BW_in;
  localparam int BW_sum     = 14;
  localparam int BW_out     = 8;
  localparam int CNT_W      = $clog2(N_TAPS + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_TAPS - 1);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_IDLE = 2'd1,
    S_MAC  = 2'd2
  } state_t;

endpackage

// File: rtl/fir_tap_scheduler_if.sv
// Coefficient, sample and output handshake bundle between the pin mux and the FIR sequencer.
interface fir_tap_scheduler_if;
  import fir_pkg::*;

  logic                     coef_valid;
  logic signed [BW_in-1:0]  coef_data;
  logic                     coef_ready;
  logic                     sample_valid;
  logic signed [BW_in-1:0]  sample_data;
  logic                     sample_ready;
  logic                     y_valid;
  logic        [BW_out-1:0] y_data;

  modport master (
    output coef_valid, coef_data, sample_valid, sample_data,
    input  coef_ready, sample_ready, y_valid, y_data
  );

  modport slave (
    input  coef_valid, coef_data, sample_valid, sample_data,
    output coef_ready, sample_ready, y_valid, y_data
  );

endinterface

// File: rtl/fir_tap_scheduler_mac.sv
// Shared multiply-accumulate: signed BW_in x BW_in product added into a wrapping BW_sum accumulator.
module fir_mac
  import fir_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_clr,
  input  logic                     i_en,
  input  logic signed [BW_in-1:0]  i_x,
  input  logic signed [BW_in-1:0]  i_c,
  output logic signed [BW_sum-1:0] o_sum
);

  logic signed [BW_product-1:0] w_prod;
  logic signed [BW_sum-1:0]     w_prod_ext;
  logic signed [BW_sum-1:0]     r_acc;

  assign w_prod     = i_x * i_c;
  assign w_prod_ext = {{(BW_sum - BW_product){w_prod[BW_product-1]}}, w_prod};
  // o_sum is the value the accumulator takes on this edge; the last tap reads it directly
  assign o_sum      = r_acc + w_prod_ext;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= o_sum;
    end
  end

endmodule

// File: rtl/fir_tap_scheduler.sv
// Single-multiplier FIR sequencer: coefficient/sample register files, tap mux and control FSM.
// Build option FIR_OUT_SAT_EN: saturate the output word instead of truncating it.
//
// state | meaning
// ------+-----------------------------------------------------------
// LOAD  | shifting in coefficients until N_TAPS have been written
// IDLE  | waiting for a sample; a coefficient write restarts loading
// MAC   | one tap per cycle through the shared multiplier
module fir_tap_scheduler
  import fir_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  fir_tap_scheduler_if.slave bus
);

  state_t r_state, w_state_nxt;

  logic [CNT_W-1:0]        r_coef_cnt;
  logic [CNT_W-1:0]        r_tap;
  logic signed [BW_in-1:0] r_coef [N_TAPS];
  logic signed [BW_in-1:0] r_x    [N_TAPS];
  logic [BW_out-1:0]       r_y_data;
  logic                    r_y_valid;

  logic w_coef_shift, w_coef_restart, w_x_shift, w_x_clr;
  logic w_mac_clr, w_mac_en, w_y_load;

  logic signed [BW_in-1:0]  w_x_tap, w_c_tap;
  logic signed [BW_sum-1:0] w_sum;
  logic [BW_out-1:0]        w_y_nxt;

  always_comb begin
    w_state_nxt    = r_state;
    w_coef_shift   = 1'b0;
    w_coef_restart = 1'b0;
    w_x_shift      = 1'b0;
    w_x_clr        = 1'b0;
    w_mac_clr      = 1'b0;
    w_mac_en       = 1'b0;
    w_y_load       = 1'b0;
    unique case (r_state)
      S_LOAD: begin
        if (bus.coef_valid) begin
          w_coef_shift = 1'b1;
          if (r_coef_cnt == CNT_LAST) w_state_nxt = S_IDLE;
        end
      end
      S_IDLE: begin
        // a coefficient write wins over a simultaneous sample
        if (bus.coef_valid) begin
          w_coef_shift   = 1'b1;
          w_coef_restart = 1'b1;
          w_x_clr        = 1'b1;
          w_state_nxt    = S_LOAD;
        end else if (bus.sample_valid) begin
          w_x_shift   = 1'b1;
          w_mac_clr   = 1'b1;
          w_state_nxt = S_MAC;
        end
      end
      S_MAC: begin
        w_mac_en = 1'b1;
        if (r_tap == CNT_LAST) begin
          w_y_load    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_LOAD;
      r_coef_cnt <= '0;
      r_tap      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_coef_restart)    r_coef_cnt <= CNT_W'(1);
      else if (w_coef_shift) r_coef_cnt <= r_coef_cnt + 1'b1;
      if (w_mac_clr)         r_tap <= '0;
      else if (w_mac_en)     r_tap <= r_tap + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < N_TAPS; k++) begin
        r_coef[k] <= '0;
        r_x[k]    <= '0;
      end
    end else begin
      if (w_coef_shift) begin
        for (int k = N_TAPS - 1; k > 0; k--) r_coef[k] <= r_coef[k-1];
        r_coef[0] <= bus.coef_data;
      end
      if (w_x_clr) begin
        for (int k = 0; k < N_TAPS; k++) r_x[k] <= '0;
      end else if (w_x_shift) begin
        for (int k = N_TAPS - 1; k > 0; k--) r_x[k] <= r_x[k-1];
        r_x[0] <= bus.sample_data;
      end
    end
  end

  assign w_x_tap = r_x[r_tap];
  assign w_c_tap = r_coef[r_tap];

  fir_mac u_mac (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (w_mac_clr),
    .i_en    (w_mac_en),
    .i_x     (w_x_tap),
    .i_c     (w_c_tap),
    .o_sum   (w_sum)
  );

`ifdef FIR_OUT_SAT_EN
  localparam logic signed [BW_sum-1:0] SUM_MAX = BW_sum'(2**(BW_out-1) - 1);
  localparam logic signed [BW_sum-1:0] SUM_MIN = BW_sum'(-(2**(BW_out-1)));

  always_comb begin
    w_y_nxt = w_sum[BW_out-1:0];
    if (w_sum > SUM_MAX)      w_y_nxt = {1'b0, {(BW_out-1){1'b1}}};
    else if (w_sum < SUM_MIN) w_y_nxt = {1'b1, {(BW_out-1){1'b0}}};
  end
`else
  logic w_unused_sum_msb;
  assign w_y_nxt          = w_sum[BW_out-1:0];
  assign w_unused_sum_msb = ^w_sum[BW_sum-1:BW_out];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_y_valid <= 1'b0;
      r_y_data  <= '0;
    end else begin
      r_y_valid <= w_y_load;
      if (w_y_load) r_y_data <= w_y_nxt;
    end
  end

  assign bus.coef_ready   = (r_state == S_LOAD) || (r_state == S_IDLE);
  assign bus.sample_ready = (r_state == S_IDLE);
  assign bus.y_valid      = r_y_valid;
  assign bus.y_data       = r_y_data;

endmodule

// File: tb/tb_fir_tap_scheduler.sv
// Directed bench for fir_tap_scheduler: impulse, wrap/saturation, throughput, coefficient reload and reset abort.
module tb_fir_tap_scheduler;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_err;

  fir_tap_scheduler_if bus ();

  fir_tap_scheduler dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] exp_out(input int s);
    logic [31:0] t;
`ifdef FIR_OUT_SAT_EN
    if (s > 127)  return 8'h7F;
    if (s < -128) return 8'h80;
`endif
    t = s;
    return t[7:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // called and returns on a falling edge; one coefficient per cycle
  task automatic load(input int v);
    bus.coef_valid = 1'b1;
    bus.coef_data  = 6'(v);
    @(negedge clk);
    bus.coef_valid = 1'b0;
  endtask

  task automatic send(input int v, input int exp_y, input string tag, input bit coef_in_mac);
    int w;
    int lat;
    logic [7:0] y_hold;
    w = 0;
    while (!bus.sample_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_ready"}, bus.sample_ready, 1);
    bus.sample_valid = 1'b1;
    bus.sample_data  = 6'(v);
    @(negedge clk);
    bus.sample_valid = 1'b0;
    if (coef_in_mac) begin
      bus.coef_valid = 1'b1;
      bus.coef_data  = 6'sd31;
    end
    lat = 0;
    while (!bus.y_valid && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 2) bus.coef_valid = 1'b0;
    end
    check({tag, "_lat"}, lat, 5);
    check({tag, "_y"}, bus.y_data, exp_out(exp_y));
    check({tag, "_rdy_with_y"}, bus.sample_ready, 1);
    y_hold = bus.y_data;
    @(negedge clk);
    check({tag, "_pulse"}, bus.y_valid, 0);
    check({tag, "_hold"}, bus.y_data, y_hold);
  endtask

  initial begin
    int acc_cyc [4];
    int ys [4];
    int acc_n;
    int yn;
    int cyc;
    int pulses;
    bit prev;

    n_checks = 0;
    n_err    = 0;
    reset_n  = 1'b1;
    bus.coef_valid   = 1'b0;
    bus.coef_data    = '0;
    bus.sample_valid = 1'b0;
    bus.sample_data  = '0;

    #2 reset_n = 1'b0;
    @(negedge clk);
    check("rst_coef_ready", bus.coef_ready, 1);
    check("rst_sample_ready", bus.sample_ready, 0);
    check("rst_y_valid", bus.y_valid, 0);
    check("rst_y_data", bus.y_data, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // first coefficient lands in the last tap, so c = {5,4,3,2,1}
    for (int i = 1; i <= 4; i++) load(i);
    check("load4_not_ready", bus.sample_ready, 0);
    load(5);
    check("load5_ready", bus.sample_ready, 1);
    check("load5_coef_ready", bus.coef_ready, 1);

    send(1, 5, "imp0", 1'b0);
    send(0, 4, "imp1", 1'b0);
    send(0, 3, "imp2", 1'b0);
    send(0, 2, "imp3", 1'b0);
    send(0, 1, "imp4", 1'b0);
    send(0, 0, "imp5", 1'b0);
    send(7, 35, "seven", 1'b0);

    #2 reset_n = 1'b0;
    #1;
    check("arst_y_data", bus.y_data, 0);
    check("arst_y_valid", bus.y_valid, 0);
    check("arst_sample_ready", bus.sample_ready, 0);
    check("arst_coef_ready", bus.coef_ready, 1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) load(-32);
    send(-32, 1024, "neg1", 1'b0);
    send(-32, 2048, "neg2", 1'b0);
    send(-32, 3072, "neg3", 1'b0);
    send(-32, 4096, "neg4", 1'b0);
    send(-32, 5120, "neg5", 1'b0);

    load(1);
    check("reload_coef_ready", bus.coef_ready, 1);
    check("reload_not_ready", bus.sample_ready, 0);
    bus.sample_valid = 1'b1;
    bus.sample_data  = 6'sd9;
    load(2);
    load(3);
    load(4);
    check("reload4_not_ready", bus.sample_ready, 0);
    bus.sample_valid = 1'b0;
    load(5);
    check("reload5_ready", bus.sample_ready, 1);
    send(1, 5, "reload_xclr", 1'b0);

    // x = {1,0,0,0,0}; stream 2,3,4,5 with sample_valid held
    bus.sample_data  = 6'sd2;
    bus.sample_valid = 1'b1;
    acc_n = 0;
    yn    = 0;
    cyc   = 0;
    prev  = 1'b0;
    while (yn < 4 && cyc < 80) begin
      if (prev) begin
        bus.sample_data = bus.sample_data + 6'sd1;
        if (acc_n == 4) bus.sample_valid = 1'b0;
      end
      prev = bus.sample_ready && bus.sample_valid;
      if (prev && acc_n < 4) begin
        acc_cyc[acc_n] = cyc;
        acc_n++;
      end
      if (bus.y_valid && yn < 4) begin
        ys[yn] = int'(bus.y_data);
        yn++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.sample_valid = 1'b0;
    check("tp_accepts", acc_n, 4);
    check("tp_outputs", yn, 4);
    check("tp_gap1", acc_cyc[1] - acc_cyc[0], 6);
    check("tp_gap2", acc_cyc[2] - acc_cyc[1], 6);
    check("tp_gap3", acc_cyc[3] - acc_cyc[2], 6);
    check("tp_y0", ys[0], 14);
    check("tp_y1", ys[1], 26);
    check("tp_y2", ys[2], 40);
    check("tp_y3", ys[3], 55);

    // x = {5,4,3,2,1}; coefficient writes during MAC must be dropped
    send(0, 40, "mac_coef", 1'b1);
    check("mac_coef_state", bus.sample_ready, 1);
    send(0, 26, "mac_coef_after", 1'b0);

    bus.sample_valid = 1'b1;
    bus.sample_data  = 6'sd1;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    check("abort_y_valid", bus.y_valid, 0);
    @(negedge clk);
    reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.y_valid) pulses++;
    end
    check("abort_no_pulse", pulses, 0);
    check("abort_coef_ready", bus.coef_ready, 1);
    check("abort_sample_ready", bus.sample_ready, 0);
    for (int i = 1; i <= 4; i++) load(i);
    check("abort_load4", bus.sample_ready, 0);
    load(5);
    check("abort_load5", bus.sample_ready, 1);
    send(3, 15, "abort_after", 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
